// File: rtl/gpio_cfg_serial_loader.sv
// gpio_cfg_serial_loader
//   Walks the user GPIO configuration chain. On start it reads one CFG_BITS word
//   per pad from a config register file (far-end pad first) and shifts each word
//   MSB first into the daisy-chained pad control blocks. It then pulses
//   serial_load so the shadow registers are transferred to the active pad controls.
//
// Ports
//   clk, resetn          system clock, asynchronous active-low reset
//   start, clear_chain   1-cycle request (only honoured in IDLE); clear_chain=1
//                        pulses serial_resetn before shifting
//   busy, done           sequence in progress / 1-cycle completion pulse
//   cfg_rd, cfg_addr     config read strobe and pad index
//   cfg_data             read data
//   serial_clock         chain shift clock (low outside SHIFT)
//   serial_data          chain data; held stable for a whole bit
//   serial_load          chain transfer strobe (shadow -> active)
//   serial_resetn        chain reset, active low
//
// Read handshake: cfg_rd is a single-cycle strobe with cfg_addr valid in the same
// cycle. The register file must return cfg_data exactly one cycle later. There is
// no ready/backpressure on this interface.
//
// The FSM state is held in state_q, which can be probed hierarchically.
module gpio_cfg_serial_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        clear_chain,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_rd,
  output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]         cfg_data,
  output logic                        serial_clock,
  output logic                        serial_data,
  output logic                        serial_load,
  output logic                        serial_resetn
);

  localparam int AW = $clog2(NUM_PADS);
  // One counter serves both the half-bit timer (0..CLK_DIV-1) and the
  // CLR/LOAD timer (0..2*CLK_DIV-1), so it is sized for the longer count.
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LONG_END = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(CFG_BITS - 1);
  localparam logic [AW-1:0] PAD_TOP  = AW'(NUM_PADS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_CAPT,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       bit_q;
  logic                phase_q;     // 0 = low half of a bit, 1 = high half
  logic [AW-1:0]       pad_q;
  logic [CFG_BITS-1:0] sh_q;
  logic [CFG_BITS-1:0] sh_next;
  logic                sdata_q;
  logic                chain_rst_q; // releases the chain one edge after reset

  logic half_done;
  logic long_done;
  logic last_bit;

  always_comb begin
    half_done = (cnt_q == HALF_END);
    long_done = (cnt_q == LONG_END);
    last_bit  = half_done && phase_q && (bit_q == BIT_END);
    sh_next   = sh_q << 1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = clear_chain ? S_CLR : S_FETCH;
      S_CLR:   if (long_done) state_d = S_FETCH;
      S_FETCH: state_d = S_CAPT;
      S_CAPT:  state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = (pad_q == '0) ? S_LOAD : S_FETCH;
      S_LOAD:  if (long_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: counters, pad index, shift register and serial data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      pad_q       <= '0;
      sh_q        <= '0;
      sdata_q     <= 1'b0;
      chain_rst_q <= 1'b0;
    end else begin
      chain_rst_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pad_q <= PAD_TOP;
            cnt_q <= '0;
          end
        end
        S_CLR, S_LOAD: begin
          cnt_q <= long_done ? '0 : cnt_q + 1'b1;
        end
        S_CAPT: begin
          // The first bit is driven from the first SHIFT cycle onward.
          sh_q    <= cfg_data;
          sdata_q <= cfg_data[CFG_BITS-1];
          cnt_q   <= '0;
          bit_q   <= '0;
          phase_q <= 1'b0;
        end
        S_SHIFT: begin
          if (half_done) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
            // End of the high half closes the bit; data only moves here,
            // i.e. at the same edge serial_clock returns low.
            if (phase_q) begin
              if (bit_q == BIT_END) begin
                bit_q <= '0;
                if (pad_q != '0) pad_q <= pad_q - 1'b1;
              end else begin
                bit_q   <= bit_q + 1'b1;
                sh_q    <= sh_next;
                sdata_q <= sh_next[CFG_BITS-1];
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    done          = (state_q == S_DONE);
    cfg_rd        = (state_q == S_FETCH);
    cfg_addr      = pad_q;
    serial_clock  = phase_q;
    serial_data   = sdata_q;
    serial_load   = (state_q == S_LOAD);
    serial_resetn = chain_rst_q && (state_q != S_CLR);
  end

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Bench for gpio_cfg_serial_loader: a small instance (2 pads x 3 bits, CLK_DIV=1)
// for directed sequencing checks and a default instance (38 x 13, CLK_DIV=4)
// feeding a chain model.
module tb_gpio_cfg_serial_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- small instance ----------------
  logic       resetn_s = 1'b0, start_s = 1'b0, clear_s = 1'b0;
  logic       busy_s, done_s, rd_s, sclk_s, sd_s, sload_s, srstn_s;
  logic [0:0] addr_s;
  logic [2:0] data_s = '0;
  logic [2:0] mem_s [2];

  gpio_cfg_serial_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(1)) dut_s (
    .clk(clk), .resetn(resetn_s), .start(start_s), .clear_chain(clear_s),
    .busy(busy_s), .done(done_s), .cfg_rd(rd_s), .cfg_addr(addr_s),
    .cfg_data(data_s), .serial_clock(sclk_s), .serial_data(sd_s),
    .serial_load(sload_s), .serial_resetn(srstn_s)
  );

  // register file model: data only valid the cycle after cfg_rd
  always @(posedge clk) data_s <= rd_s ? mem_s[addr_s] : 3'b000;

  // ---------------- default instance ----------------
  logic        resetn_d = 1'b0, start_d = 1'b0, clear_d = 1'b0;
  logic        busy_d, done_d, rd_d, sclk_d, sd_d, sload_d, srstn_d;
  logic [5:0]  addr_d;
  logic [12:0] data_d = '0;

  gpio_cfg_serial_loader dut_d (
    .clk(clk), .resetn(resetn_d), .start(start_d), .clear_chain(clear_d),
    .busy(busy_d), .done(done_d), .cfg_rd(rd_d), .cfg_addr(addr_d),
    .cfg_data(data_d), .serial_clock(sclk_d), .serial_data(sd_d),
    .serial_load(sload_d), .serial_resetn(srstn_d)
  );

  always @(posedge clk) data_d <= rd_d ? 13'h1803 : 13'h0000;

  // ---------------- monitors (sampled on negedge) ----------------
  int busy_cyc_s = 0, done_cnt_s = 0, edge_cnt_s = 0, stab_err_s = 0, rlow_s = 0;
  logic [31:0] bits_s [$];
  logic [31:0] addrs_s [$];
  logic psclk_s = 1'b0, psd_s = 1'b0;

  always @(negedge clk) begin
    if (busy_s) busy_cyc_s <= busy_cyc_s + 1;
    if (done_s) done_cnt_s <= done_cnt_s + 1;
    if (busy_s && !srstn_s) rlow_s <= rlow_s + 1;
    if (sclk_s && !psclk_s) begin
      edge_cnt_s <= edge_cnt_s + 1;
      bits_s.push_back({31'b0, sd_s});
    end
    if (sclk_s && (sd_s !== psd_s)) stab_err_s <= stab_err_s + 1;
    if (rd_s) addrs_s.push_back({31'b0, addr_s});
    psclk_s <= sclk_s;
    psd_s   <= sd_s;
  end

  int busy_cyc_d = 0, done_cnt_d = 0, edge_cnt_d = 0, stab_err_d = 0;
  int load_cyc_d = 0, edges_at_load_d = -1, load_sclk_err_d = 0;
  int rd_cnt_d = 0, addr_bad_d = 0, exp_addr_d = 37;
  logic [493:0] chain_d = '0, active_d = '0;
  logic psclk_d = 1'b0, psd_d = 1'b0;

  always @(negedge clk) begin
    if (busy_d) busy_cyc_d <= busy_cyc_d + 1;
    if (done_d) done_cnt_d <= done_cnt_d + 1;
    if (sclk_d && !psclk_d) begin
      edge_cnt_d <= edge_cnt_d + 1;
      chain_d    <= {chain_d[492:0], sd_d};
    end
    if (sclk_d && (sd_d !== psd_d)) stab_err_d <= stab_err_d + 1;
    if (sload_d) begin
      load_cyc_d <= load_cyc_d + 1;
      active_d   <= chain_d;
      if (load_cyc_d == 0) edges_at_load_d <= edge_cnt_d;
      if (sclk_d) load_sclk_err_d <= load_sclk_err_d + 1;
    end
    if (rd_d) begin
      rd_cnt_d <= rd_cnt_d + 1;
      if ({26'b0, addr_d} != exp_addr_d) addr_bad_d <= addr_bad_d + 1;
      exp_addr_d <= exp_addr_d - 1;
    end
    psclk_d <= sclk_d;
    psd_d   <= sd_d;
  end

  // ---------------- scoreboard / helpers ----------------
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done_s(input int bound);
    int n = 0;
    while (done_s !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_s_within_bound", {31'b0, n < bound}, 32'd1);
  endtask

  task automatic wait_done_d(input int bound);
    int n = 0;
    while (done_d !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_d_within_bound", {31'b0, n < bound}, 32'd1);
  endtask

  task automatic pulse_start_s(input logic clr);
    start_s = 1'b1;
    clear_s = clr;
    @(negedge clk);
    start_s = 1'b0;
    clear_s = 1'b0;
  endtask

  task automatic chk_reset_vals_s(input string tag);
    chk({tag, "_busy"},  {31'b0, busy_s},  32'd0);
    chk({tag, "_done"},  {31'b0, done_s},  32'd0);
    chk({tag, "_rd"},    {31'b0, rd_s},    32'd0);
    chk({tag, "_addr"},  {31'b0, addr_s},  32'd0);
    chk({tag, "_sclk"},  {31'b0, sclk_s},  32'd0);
    chk({tag, "_sd"},    {31'b0, sd_s},    32'd0);
    chk({tag, "_sload"}, {31'b0, sload_s}, 32'd0);
    chk({tag, "_srstn"}, {31'b0, srstn_s}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b0, e0, d0, a0, k0, r0;
    mem_s[1] = 3'b101;
    mem_s[0] = 3'b011;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals_s("rst");
    chk("rst_d_busy",  {31'b0, busy_d},  32'd0);
    chk("rst_d_srstn", {31'b0, srstn_d}, 32'd0);
    resetn_s = 1'b1;
    resetn_d = 1'b1;
    @(negedge clk);
    chk("rel_srstn_s", {31'b0, srstn_s}, 32'd1);
    chk("rel_srstn_d", {31'b0, srstn_d}, 32'd1);
    chk("rel_busy_s",  {31'b0, busy_s},  32'd0);
    @(negedge clk);

    // test 1: clear=0, stepwise walk of the first pad then full-run totals
    b0 = busy_cyc_s; e0 = edge_cnt_s; d0 = done_cnt_s;
    a0 = addrs_s.size(); k0 = bits_s.size();
    pulse_start_s(1'b0);
    chk("t1_fetch_busy", {31'b0, busy_s}, 32'd1);
    chk("t1_fetch_rd",   {31'b0, rd_s},   32'd1);
    chk("t1_fetch_addr", {31'b0, addr_s}, 32'd1);
    @(negedge clk);
    chk("t1_capt_rd",    {31'b0, rd_s},   32'd0);
    chk("t1_capt_sclk",  {31'b0, sclk_s}, 32'd0);
    @(negedge clk);
    chk("t1_bit0_sd",    {31'b0, sd_s},   32'd1);
    chk("t1_bit0_sclk",  {31'b0, sclk_s}, 32'd0);
    @(negedge clk);
    chk("t1_bit0_sclk_hi", {31'b0, sclk_s}, 32'd1);
    wait_done_s(100);
    chk("t1_done_busy", {31'b0, busy_s}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_busy_cycles", busy_cyc_s - b0, 32'd18);
    chk("t1_edges",       edge_cnt_s - e0, 32'd6);
    chk("t1_done_pulses", done_cnt_s - d0, 32'd1);
    chk("t1_reads",       addrs_s.size() - a0, 32'd2);
    chk("t1_addr_first",  addrs_s[a0],     32'd1);
    chk("t1_addr_second", addrs_s[a0 + 1], 32'd0);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_bit%0d", i), bits_s[k0 + i], exp_q.pop_front());

    // test 2: clear_chain=1
    b0 = busy_cyc_s; e0 = edge_cnt_s; r0 = rlow_s;
    pulse_start_s(1'b1);
    chk("t2_clr_busy",   {31'b0, busy_s},  32'd1);
    chk("t2_clr_srstn0", {31'b0, srstn_s}, 32'd0);
    chk("t2_clr_rd",     {31'b0, rd_s},    32'd0);
    @(negedge clk);
    chk("t2_clr_srstn1", {31'b0, srstn_s}, 32'd0);
    @(negedge clk);
    chk("t2_fetch_srstn", {31'b0, srstn_s}, 32'd1);
    chk("t2_fetch_rd",    {31'b0, rd_s},    32'd1);
    chk("t2_fetch_addr",  {31'b0, addr_s},  32'd1);
    wait_done_s(100);
    @(negedge clk);
    @(negedge clk);
    chk("t2_busy_cycles", busy_cyc_s - b0, 32'd20);
    chk("t2_rstn_low",    rlow_s - r0,     32'd2);
    chk("t2_edges",       edge_cnt_s - e0, 32'd6);

    // test 3: second start 5 cycles in is ignored
    b0 = busy_cyc_s; d0 = done_cnt_s;
    pulse_start_s(1'b0);
    repeat (4) @(negedge clk);
    pulse_start_s(1'b0);
    wait_done_s(100);
    repeat (4) @(negedge clk);
    chk("t3_done_pulses", done_cnt_s - d0, 32'd1);
    chk("t3_busy_cycles", busy_cyc_s - b0, 32'd18);
    chk("t3_idle_after",  {31'b0, busy_s}, 32'd0);
    pulse_start_s(1'b0);
    chk("t3_restart_busy", {31'b0, busy_s}, 32'd1);
    chk("t3_restart_rd",   {31'b0, rd_s},   32'd1);
    wait_done_s(100);
    @(negedge clk);
    chk("t3_done_total", done_cnt_s - d0, 32'd2);

    // test 4: async reset during pad 1 shift
    pulse_start_s(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre_busy", {31'b0, busy_s}, 32'd1);
    chk("t4_pre_sclk", {31'b0, sclk_s}, 32'd1);
    #1 resetn_s = 1'b0;
    #1 chk_reset_vals_s("t4_async");
    @(negedge clk);
    resetn_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_post_busy",  {31'b0, busy_s},  32'd0);
    chk("t4_post_done",  {31'b0, done_s},  32'd0);
    chk("t4_post_srstn", {31'b0, srstn_s}, 32'd1);
    b0 = busy_cyc_s; e0 = edge_cnt_s;
    pulse_start_s(1'b0);
    wait_done_s(100);
    @(negedge clk);
    @(negedge clk);
    chk("t4_rerun_busy",  busy_cyc_s - b0, 32'd18);
    chk("t4_rerun_edges", edge_cnt_s - e0, 32'd6);
    chk("s_data_stable",  stab_err_s,      32'd0);

    // test 5: default parameters, every word 13'h1803
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    wait_done_d(5000);
    @(negedge clk);
    @(negedge clk);
    chk("d_edges",         edge_cnt_d,      32'd494);
    chk("d_busy_cycles",   busy_cyc_d,      32'd4036);
    chk("d_load_cycles",   load_cyc_d,      32'd8);
    chk("d_edges_at_load", edges_at_load_d, 32'd494);
    chk("d_load_sclk",     load_sclk_err_d, 32'd0);
    chk("d_reads",         rd_cnt_d,        32'd38);
    chk("d_addr_order",    addr_bad_d,      32'd0);
    chk("d_done_pulses",   done_cnt_d,      32'd1);
    chk("d_data_stable",   stab_err_d,      32'd0);
    for (int p = 0; p < 38; p++)
      chk($sformatf("d_pad%0d", p), {19'b0, active_d[p*13 +: 13]}, 32'h1803);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
